// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift register forms the
// window, which doubles as the registered window output.
// Optional build macro: WINGEN_FRAME_CHECK_EN enables the sticky framing-error flag.
module window_gen_3x3 #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 48,
  parameter int unsigned PIX_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [9*PIX_W-1:0]            win,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  cx,
  output logic [$clog2(IMG_HEIGHT)-1:0] cy,
  output logic                          frame_done,
  output logic                          err
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {StIdle, StPrime, StStream} state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, x_cur;
  logic [YW-1:0]    y_q, y_d, y_cur;
  logic             accept, last_pix, win_ok;

  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;

  logic [9*PIX_W-1:0] win_q, win_d;
  logic               win_valid_q;
  logic [XW-1:0]      cx_q, cx_d;
  logic [YW-1:0]      cy_q, cy_d;
  logic               frame_done_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and raster counters; sof always restarts at (0,0)
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      if (last_pix) begin
        x_d     = '0;
        y_d     = '0;
        state_d = StIdle;
      end else begin
        if (x_cur == XW'(IMG_WIDTH - 1)) begin
          x_d = '0;
          y_d = y_cur + YW'(1);
        end else begin
          x_d = x_cur + XW'(1);
          y_d = y_cur;
        end
        state_d = (y_d >= YW'(2)) ? StStream : StPrime;
      end
    end
  end

  // Accept qualification and effective coordinates of the incoming pixel
  always_comb begin
    accept   = pix_valid && (sof || (state_q != StIdle));
    x_cur    = sof ? '0 : x_q;
    y_cur    = sof ? '0 : y_q;
    // x_cur is forced to 0 by sof, so sof beats the last-pixel condition
    last_pix = (x_cur == XW'(IMG_WIDTH - 1)) && (y_cur == YW'(IMG_HEIGHT - 1));
    win_ok   = (x_cur >= XW'(2)) && (y_cur >= YW'(2));
  end

  // Line buffer read at the current column
  always_comb begin
    lb1_rd = lb1[x_cur];
    lb2_rd = lb2[x_cur];
  end

  // Line buffers: lb1 holds row y-1, lb2 row y-2; contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb2[x_cur] <= lb1_rd;
      lb1[x_cur] <= pix_in;
    end
  end

  // Window shift and centre-coordinate next values
  always_comb begin
    win_d = win_q;
    cx_d  = cx_q;
    cy_d  = cy_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3+0)*PIX_W +: PIX_W] = win_q[(r*3+1)*PIX_W +: PIX_W];
        win_d[(r*3+1)*PIX_W +: PIX_W] = win_q[(r*3+2)*PIX_W +: PIX_W];
      end
      win_d[2*PIX_W +: PIX_W] = lb2_rd;
      win_d[5*PIX_W +: PIX_W] = lb1_rd;
      win_d[8*PIX_W +: PIX_W] = pix_in;
      if (win_ok) begin
        cx_d = x_cur - XW'(1);
        cy_d = y_cur - YW'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      win_valid_q  <= accept && win_ok;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      frame_done_q <= accept && last_pix;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign cx         = cx_q;
  assign cy         = cy_q;
  assign frame_done = frame_done_q;

`ifdef WINGEN_FRAME_CHECK_EN
  logic err_q;

  // Sticky framing error: early sof mid-frame, or stray pixels while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (pix_valid && sof && (state_q != StIdle)) begin
      err_q <= 1'b1;
    end else if (pix_valid && !sof && (state_q == StIdle)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 frame with a window scoreboard.
module tb_window_gen_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 4;

`ifdef WINGEN_FRAME_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  typedef struct packed {
    logic [9*PW-1:0] w;
    logic [2:0]      cx;
    logic [1:0]      cy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   pix_in;
  logic            pix_valid;
  logic            sof;
  logic [9*PW-1:0] win;
  logic            win_valid;
  logic [2:0]      cx;
  logic [1:0]      cy;
  logic            frame_done;
  logic            err;

  window_gen_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .win       (win),
    .win_valid (win_valid),
    .cx        (cx),
    .cy        (cy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int              n_cmp = 0;
  int              n_err = 0;
  exp_t            exp_q[$];
  logic [PW-1:0]   img [H][W];
  logic            fd_exp = 1'b0;
  int              win_cnt = 0;
  logic [9*PW-1:0] first_win, last_win;
  logic [2:0]      last_cx;
  logic [1:0]      last_cy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one pixel; push the expected window if this pixel completes one.
  task automatic send_pix(input logic [PW-1:0] v, input logic s, input int x, input int y,
                          input int gap);
    exp_t            e;
    logic [9*PW-1:0] held;
    img[y][x] = v;
    if (x >= 2 && y >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.w[(r*3+c)*PW +: PW] = img[y-2+r][x-2+c];
      e.cx = 3'(x - 1);
      e.cy = 2'(y - 1);
      exp_q.push_back(e);
    end
    pix_in    = v;
    sof       = s;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    fd_exp    = (x == W - 1) && (y == H - 1);
    if (gap > 0) begin
      @(negedge clk);
      held = win;
      repeat (gap) begin
        @(negedge clk);
        check("win_hold", win, held);
      end
    end
  endtask

  task automatic send_frame(input int n_pix, input bit gaps);
    int g;
    for (int i = 0; i < n_pix; i++) begin
      g = 0;
      if (gaps && $urandom_range(0, 1) == 1) g = $urandom_range(1, 3);
      send_pix(PW'(i % 16), i == 0, i % W, i / W, g);
    end
  endtask

  task automatic finish_frame(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 64'(win_cnt), 64'((W - 2) * (H - 2)));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: pops the scoreboard on every valid window
  always @(negedge clk) begin
    exp_t e;
    check("frame_done", frame_done, fd_exp);
    fd_exp = 1'b0;
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        check("win_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("win", win, e.w);
        check("cx", cx, e.cx);
        check("cy", cy, e.cy);
      end
      if (win_cnt == 0) first_win = win;
      last_win = win;
      last_cx  = cx;
      last_cy  = cy;
      win_cnt++;
    end
  end

  initial begin
    int              lw [9];
    logic [9*PW-1:0] cw;

    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    sof       = 1'b0;

    // Reset only
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_win", win, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_err", err, 0);

    // Contiguous frame
    win_cnt = 0;
    @(posedge clk);
    #1;
    send_frame(W * H, 1'b0);
    finish_frame("contig");
    lw = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    for (int k = 0; k < 9; k++) cw[k*PW +: PW] = lw[k][PW-1:0];
    check("first_win_const", first_win, cw);
    lw = '{7, 8, 9, 12, 13, 14, 1, 2, 3};
    for (int k = 0; k < 9; k++) cw[k*PW +: PW] = lw[k][PW-1:0];
    check("last_win_const", last_win, cw);
    check("last_cx_const", last_cx, 3);
    check("last_cy_const", last_cy, 2);
    check("contig_err", err, 0);

    // Same frame with random gaps
    win_cnt = 0;
    send_frame(W * H, 1'b1);
    finish_frame("gaps");

    // Reset mid-frame after pixel 8, then a full frame
    send_frame(9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_win", win, 0);
    check("midrst_win_valid", win_valid, 0);
    check("midrst_cx", cx, 0);
    check("midrst_cy", cy, 0);
    rst = 1'b0;
    win_cnt = 0;
    send_frame(W * H, 1'b0);
    finish_frame("after_rst");
    check("after_rst_err", err, 0);

    // Early sof at pixel 10 restarts the frame
    send_frame(10, 1'b0);
    win_cnt = 0;
    send_frame(W * H, 1'b0);
    finish_frame("restart");
    check("restart_err", err, ErrExp);

    // Stray pixels in IDLE without sof are dropped
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_err", err, 0);
    win_cnt = 0;
    for (int i = 0; i < 3; i++) send_pix(PW'(9 + i), 1'b0, i, 0, 0);
    repeat (3) @(negedge clk);
    check("idle_no_win", 64'(win_cnt), 0);
    check("idle_err", err, ErrExp);

    // Normal frame still works after the dropped pixels; err stays sticky
    win_cnt = 0;
    send_frame(W * H, 1'b0);
    finish_frame("post_idle");
    check("post_idle_err", err, ErrExp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Builds 3x3 pixel windows from a raster-order pixel stream using two line buffers and a 3x3 shift register.
- Sits directly upstream of the gaussian_mac, sobel_h and sobel_v kernels.
- Presents each valid window as a registered 9-pixel bus, plus the coordinates of the window's centre pixel.
- No backpressure: the downstream kernels are combinational and always accept.

Parameters:
- IMG_WIDTH, 64, pixels per line (minimum 3).
- IMG_HEIGHT, 48, lines per frame (minimum 3).
- PIX_W, 4, bits per pixel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  PIX_W  pixel data.
- pix_valid  input  1  pix_in valid this cycle; accepted unconditionally.
- sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- win  output  9*PIX_W  window; element [r][c] at bits ((r*3+c)*PIX_W) +: PIX_W. r=0 is the top (oldest) row, c=0 is the left (oldest) column.
- win_valid  output  1  win, cx and cy valid.
- cx  output  $clog2(IMG_WIDTH)  centre column.
- cy  output  $clog2(IMG_HEIGHT)  centre row.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.
- err  output  1  sticky framing error (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, state = IDLE, x = y = 0. Line-buffer contents are don't-care.
- States: IDLE, PRIME (y<2), STREAM (y>=2).
- Accept condition: accept = pix_valid && (sof || state != IDLE).
  - In IDLE, pix_valid without sof is dropped.
  - pix_valid && sof in any state restarts the frame: the pixel is taken as (0,0) and state goes to PRIME.
- Column counter x and row counter y are updated on accept only:
  - x wraps at IMG_WIDTH-1 to 0 and increments y.
  - PRIME -> STREAM when y becomes 2.
  - On accepting (IMG_WIDTH-1, IMG_HEIGHT-1): state goes to IDLE and frame_done pulses the next cycle.
- Line buffers lb1 (row y-1) and lb2 (row y-2), each IMG_WIDTH x PIX_W. On accept at column x:
  - read lb1[x] and lb2[x];
  - write lb2[x] <= lb1[x] and lb1[x] <= pix_in.
- Window shift on accept:
  - columns 0 <= 1 <= 2;
  - new column 2 = {row0: lb2[x], row1: lb1[x], row2: pix_in}.
- win_valid <= accept && x>=2 && y>=2, with cx <= x-1 and cy <= y-1 registered in the same cycle.
  - Latency is 1 clock from acceptance of the bottom-right pixel.
  - Produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. Edge pixels get no window.
- Gaps in pix_valid: win, cx and cy hold; win_valid is 0 in non-accept cycles.
- Edge windows: windows built from stale columns at x<2 are never flagged valid.
- Simultaneous events:
  - sof together with the last-pixel condition: sof wins.
  - rst has priority over everything.
- Reset mid-frame: all outputs are cleared next cycle and the partial frame is abandoned. The next accepted pixel must carry sof.

Optional Feature:
- Macro: WINGEN_FRAME_CHECK_EN.
- Defined: err is set (sticky until rst) on either condition:
  - sof accepted while state != IDLE (early sof / short frame);
  - pix_valid without sof while state == IDLE (extra pixels).
- Defined: the offending pixel handling is unchanged from Behaviour (restart or drop).
- Not defined: err is tied to 0 and no checking logic is present.

Test Plan:
- Reset only, 5 cycles -> all outputs 0; no win_valid.
- IMG_WIDTH=5, IMG_HEIGHT=4, 20 contiguous pixels, value = index mod 16, sof on index 0:
  - first win_valid occurs 1 cycle after index 12, with rows {0,1,2},{5,6,7},{10,11,12}, cx=1, cy=1;
  - exactly 6 windows, last one at cx=3, cy=2 with rows {7,8,9},{12,13,14},{1,2,3};
  - frame_done pulses 1 cycle after index 19.
- Same frame with random 1-3 cycle gaps in pix_valid -> identical window sequence; win holds during gaps.
- rst asserted after pixel 8, then a full frame with sof -> outputs cleared; the second frame yields the same 6 windows as the contiguous case.
- Second sof at pixel 10 (WINGEN_FRAME_CHECK_EN defined) -> err=1 and stays set; the restarted frame produces correct windows. Without the macro, err stays 0.
- 3 pixels in IDLE without sof -> dropped; no win_valid; err=1 only with the macro defined.
